// File: rtl/oled_pkg.sv
// Shared constants for the SSD1331 receive-side link model: panel size,
// acted-on opcodes, per-opcode argument counts and the parser state encoding.
package oled_pkg;

    localparam int unsigned OLED_WIDTH  = 96;
    localparam int unsigned OLED_HEIGHT = 64;

    localparam logic [7:0] CMD_SET_COL  = 8'h15;
    localparam logic [7:0] CMD_SET_ROW  = 8'h75;
    localparam logic [7:0] CMD_DISP_ON  = 8'hAF;
    localparam logic [7:0] CMD_DISP_OFF = 8'hAE;

    typedef enum logic {
        ST_CMD = 1'b0,
        ST_ARG = 1'b1
    } parser_state_e;

    // Argument bytes that follow each opcode; unknown opcodes take none.
    function automatic logic [3:0] arg_count(input logic [7:0] op);
        logic [3:0] n;
        case (op)
            8'h15, 8'h75:                         n = 4'd2;
            8'h81, 8'h82, 8'h83, 8'h87,
            8'h8A, 8'h8B, 8'h8C,
            8'hA0, 8'hA1, 8'hA2, 8'hA8, 8'hAD,
            8'hB0, 8'hB1, 8'hB3, 8'hBB, 8'hBE,
            8'hF0, 8'h26:                         n = 4'd1;
            8'h21:                                n = 4'd7;
            8'h22:                                n = 4'd10;
            8'h23:                                n = 4'd6;
            8'h24, 8'h25:                         n = 4'd4;
            8'h27:                                n = 4'd5;
            default:                              n = 4'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronises the link pins, detects SCK
// rises and assembles MSB-first bytes tagged with the D/C level.
module spi_byte_rx (
    input  logic       clk,
    input  logic       reset,
    input  logic       oled_csn,
    input  logic       oled_clk,
    input  logic       oled_mosi,
    input  logic       oled_dc,
    input  logic       oled_resn,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       byte_dc,
    output logic       frame_err,
    output logic       link_resn
);

    // Pin order {resn, dc, mosi, clk, csn}; idle levels keep the link deselected.
    localparam logic [4:0] SYNC_IDLE = 5'b10001;

    logic [4:0] sync1_q, sync2_q;
    logic       sck_d3_q;
    logic       csn_s, sck_s, mosi_s, dc_s, resn_s, sck_rise;

    logic [2:0] cnt_q, cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dc_q, dc_d;
    logic       valid_q, valid_d;
    logic       ferr_q, ferr_d;

    assign csn_s    = sync2_q[0];
    assign sck_s    = sync2_q[1];
    assign mosi_s   = sync2_q[2];
    assign dc_s     = sync2_q[3];
    assign resn_s   = sync2_q[4];
    assign sck_rise = sck_s & ~sck_d3_q;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dc_d    = dc_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (csn_s) begin
            ferr_d = (cnt_q != 3'd0);
            cnt_d  = 3'd0;
        end else if (sck_rise) begin
            shift_d = {shift_q[5:0], mosi_s};
            if (cnt_q == 3'd7) begin
                byte_d  = {shift_q, mosi_s};
                dc_d    = dc_s;
                valid_d = 1'b1;
                cnt_d   = 3'd0;
            end else begin
                cnt_d = cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= SYNC_IDLE;
            sync2_q  <= SYNC_IDLE;
            sck_d3_q <= 1'b0;
        end else begin
            sync1_q  <= {oled_resn, oled_dc, oled_mosi, oled_clk, oled_csn};
            sync2_q  <= sync1_q;
            sck_d3_q <= sck_s;
        end
    end

    // A link reset drops any partial byte silently, unlike a CSn abort.
    always_ff @(posedge clk) begin
        if (reset || !resn_s) begin
            cnt_q   <= 3'd0;
            shift_q <= 7'd0;
            byte_q  <= 8'd0;
            dc_q    <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dc_q    <= dc_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign rx_byte    = byte_q;
    assign byte_dc    = dc_q;
    assign frame_err  = ferr_q;
    assign link_resn  = resn_s;

endmodule

// File: rtl/oled_spi_sink.sv
// SSD1331 link sink: parses the received command stream and turns data bytes
// into framebuffer pixel writes using the column/row window cursor.
module oled_spi_sink
    import oled_pkg::*;
#(
    parameter int unsigned WIDTH  = OLED_WIDTH,
    parameter int unsigned HEIGHT = OLED_HEIGHT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       oled_csn,
    input  logic       oled_clk,
    input  logic       oled_mosi,
    input  logic       oled_dc,
    input  logic       oled_resn,
    output logic       pix_we,
    output logic [6:0] pix_x,
    output logic [5:0] pix_y,
    output logic [7:0] pix_data,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       display_on,
    output logic       frame_done,
    output logic [7:0] err_cnt
);

    localparam logic [6:0] X_MAX = 7'(WIDTH - 1);
    localparam logic [5:0] Y_MAX = 6'(HEIGHT - 1);

    logic       rx_valid, rx_dc, frame_err, link_resn;
    logic [7:0] rx_byte;

    spi_byte_rx u_rx (
        .clk        (clk),
        .reset      (reset),
        .oled_csn   (oled_csn),
        .oled_clk   (oled_clk),
        .oled_mosi  (oled_mosi),
        .oled_dc    (oled_dc),
        .oled_resn  (oled_resn),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .byte_dc    (rx_dc),
        .frame_err  (frame_err),
        .link_resn  (link_resn)
    );

    parser_state_e state_q, state_d;
    logic [3:0] args_left_q, args_left_d;
    logic [6:0] arg0_q, arg0_d;
    logic [6:0] col_start_q, col_start_d, col_end_q, col_end_d, cur_x_q, cur_x_d;
    logic [5:0] row_start_q, row_start_d, row_end_q, row_end_d, cur_y_q, cur_y_d;
    logic       pix_we_q, pix_we_d, cmd_valid_q, cmd_valid_d, frame_done_q, frame_done_d;
    logic [6:0] pix_x_q, pix_x_d;
    logic [5:0] pix_y_q, pix_y_d;
    logic [7:0] pix_data_q, pix_data_d, cmd_byte_q, cmd_byte_d, err_cnt_q, err_cnt_d;
    logic       disp_q, disp_d, abort_err;
    logic [8:0] err_sum;
    logic [3:0] n_args;

    always_comb begin
        state_d      = state_q;
        args_left_d  = args_left_q;
        arg0_d       = arg0_q;
        col_start_d  = col_start_q;
        col_end_d    = col_end_q;
        row_start_d  = row_start_q;
        row_end_d    = row_end_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        cmd_byte_d   = cmd_byte_q;
        disp_d       = disp_q;
        pix_we_d     = 1'b0;
        cmd_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        abort_err    = 1'b0;
        n_args       = arg_count(rx_byte);

        if (rx_valid && rx_dc) begin
            // Data mid-command abandons the command and is still drawn.
            abort_err  = (state_q == ST_ARG);
            state_d    = ST_CMD;
            pix_we_d   = 1'b1;
            pix_x_d    = cur_x_q;
            pix_y_d    = cur_y_q;
            pix_data_d = rx_byte;
            if (cur_x_q == col_end_q || col_start_q > col_end_q) begin
                cur_x_d = col_start_q;
                if (cur_y_q == row_end_q || row_start_q > row_end_q) begin
                    cur_y_d      = row_start_q;
                    frame_done_d = 1'b1;
                end else begin
                    cur_y_d = cur_y_q + 6'd1;
                end
            end else begin
                cur_x_d = cur_x_q + 7'd1;
            end
        end else if (rx_valid && state_q == ST_CMD) begin
            cmd_byte_d  = rx_byte;
            cmd_valid_d = 1'b1;
            args_left_d = n_args;
            if (n_args != 4'd0) state_d = ST_ARG;
            if (rx_byte == CMD_DISP_ON)  disp_d = 1'b1;
            if (rx_byte == CMD_DISP_OFF) disp_d = 1'b0;
        end else if (rx_valid) begin
            arg0_d      = rx_byte[6:0];
            args_left_d = args_left_q - 4'd1;
            if (args_left_q == 4'd1) begin
                state_d = ST_CMD;
                if (cmd_byte_q == CMD_SET_COL) begin
                    col_start_d = (arg0_q > X_MAX) ? X_MAX : arg0_q;
                    col_end_d   = (rx_byte[6:0] > X_MAX) ? X_MAX : rx_byte[6:0];
                    cur_x_d     = col_start_d;
                end else if (cmd_byte_q == CMD_SET_ROW) begin
                    row_start_d = (arg0_q[5:0] > Y_MAX) ? Y_MAX : arg0_q[5:0];
                    row_end_d   = (rx_byte[5:0] > Y_MAX) ? Y_MAX : rx_byte[5:0];
                    cur_y_d     = row_start_d;
                end
            end
        end

        err_sum   = {1'b0, err_cnt_q} + {8'd0, frame_err} + {8'd0, abort_err};
        err_cnt_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) err_cnt_q <= 8'd0;
        else       err_cnt_q <= err_cnt_d;
    end

    // The link reset pin clears everything but the error history.
    always_ff @(posedge clk) begin
        if (reset || !link_resn) begin
            state_q      <= ST_CMD;
            args_left_q  <= 4'd0;
            arg0_q       <= 7'd0;
            col_start_q  <= 7'd0;
            col_end_q    <= X_MAX;
            row_start_q  <= 6'd0;
            row_end_q    <= Y_MAX;
            cur_x_q      <= 7'd0;
            cur_y_q      <= 6'd0;
            pix_we_q     <= 1'b0;
            pix_x_q      <= 7'd0;
            pix_y_q      <= 6'd0;
            pix_data_q   <= 8'd0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= 8'd0;
            disp_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            args_left_q  <= args_left_d;
            arg0_q       <= arg0_d;
            col_start_q  <= col_start_d;
            col_end_q    <= col_end_d;
            row_start_q  <= row_start_d;
            row_end_q    <= row_end_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            pix_we_q     <= pix_we_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            disp_q       <= disp_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign pix_we     = pix_we_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_data   = pix_data_q;
    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign display_on = disp_q;
    assign frame_done = frame_done_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: bit-bangs the SPI pins and compares the
// captured pixel writes and status outputs against hand-computed values.
module tb_oled_spi_sink;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       oled_csn = 1'b1, oled_clk = 1'b0, oled_mosi = 1'b0;
    logic       oled_dc = 1'b0, oled_resn = 1'b1;
    logic       pix_we, cmd_valid, display_on, frame_done;
    logic [6:0] pix_x;
    logic [5:0] pix_y;
    logic [7:0] pix_data, cmd_byte, err_cnt;

    int checks = 0;
    int errors = 0;
    int cmd_cnt = 0;

    logic [6:0] qx[$];
    logic [5:0] qy[$];
    logic [7:0] qd[$];
    logic       qf[$];

    oled_spi_sink #(.WIDTH(96), .HEIGHT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .oled_csn   (oled_csn),
        .oled_clk   (oled_clk),
        .oled_mosi  (oled_mosi),
        .oled_dc    (oled_dc),
        .oled_resn  (oled_resn),
        .pix_we     (pix_we),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .display_on (display_on),
        .frame_done (frame_done),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pix_we) begin
            qx.push_back(pix_x);
            qy.push_back(pix_y);
            qd.push_back(pix_data);
            qf.push_back(frame_done);
        end
        if (cmd_valid) cmd_cnt++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        qx.delete(); qy.delete(); qd.delete(); qf.delete();
    endtask

    task automatic spi_bit(input logic b, input logic dc);
        oled_mosi = b;
        oled_dc   = dc;
        oled_clk  = 1'b0;
        wait_cyc(2);
        oled_clk  = 1'b1;
        wait_cyc(2);
    endtask

    task automatic spi_byte(input logic [7:0] b, input logic dc);
        oled_csn = 1'b0;
        for (int i = 7; i >= 0; i--) spi_bit(b[i], dc);
    endtask

    task automatic flush();
        oled_clk = 1'b0;
        wait_cyc(8);
    endtask

    task automatic do_reset();
        oled_clk = 1'b0;
        oled_csn = 1'b1;
        reset = 1'b1;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(4);
        @(negedge clk);
        if ({pix_we, cmd_valid, frame_done} !== 3'b000) begin
            errors++; $display("FAIL reset_strobes: got %b want 000", {pix_we, cmd_valid, frame_done});
        end
        checks++;
        reset = 1'b0;
        wait_cyc(2);
        if (cmd_byte !== 8'h00) begin
            errors++; $display("FAIL reset_cmd_byte: got %h want 00", cmd_byte);
        end
        checks++;
        if (display_on !== 1'b0) begin
            errors++; $display("FAIL reset_display_on: got %b want 0", display_on);
        end
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt);
        end
        checks++;
        if ({pix_x, pix_y} !== 13'd0) begin
            errors++; $display("FAIL reset_pix_xy: got (%0d,%0d) want (0,0)", pix_x, pix_y);
        end
        checks++;
    endtask

    task automatic test_cmd_latency();
        logic [7:0] b;
        int c0;
        b = 8'hAF;
        c0 = cmd_cnt;
        oled_csn = 1'b0;
        for (int i = 7; i >= 1; i--) spi_bit(b[i], 1'b0);
        oled_mosi = b[0];
        oled_clk  = 1'b0;
        wait_cyc(2);
        oled_clk  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early: cmd_valid got %b want 0 at N+3", cmd_valid);
        end
        checks++;
        @(posedge clk);
        @(negedge clk);
        if ({cmd_valid, cmd_byte, display_on} !== {1'b1, 8'hAF, 1'b1}) begin
            errors++;
            $display("FAIL latency_n4: got valid=%b byte=%h on=%b want 1 af 1",
                     cmd_valid, cmd_byte, display_on);
        end
        checks++;
        @(negedge clk);
        if (cmd_valid !== 1'b0) begin
            errors++; $display("FAIL latency_one_cycle: cmd_valid got %b want 0", cmd_valid);
        end
        checks++;
        flush();
        if (cmd_cnt - c0 !== 1) begin
            errors++; $display("FAIL cmd_pulse_count: got %0d want 1", cmd_cnt - c0);
        end
        checks++;
    endtask

    task automatic test_frame();
        int n;
        spi_byte(8'h15, 1'b0); spi_byte(8'h00, 1'b0); spi_byte(8'h5F, 1'b0);
        spi_byte(8'h75, 1'b0); spi_byte(8'd60, 1'b0); spi_byte(8'h3F, 1'b0);
        flush();
        clear_q();
        for (int i = 0; i < 384; i++) spi_byte(8'(i), 1'b1);
        spi_byte(8'h5A, 1'b1);
        flush();
        n = qx.size();
        if (n !== 385) begin
            errors++; $display("FAIL frame_count: got %0d writes want 385", n);
        end
        checks++;
        for (int i = 0; i < 385 && i < n; i++) begin
            logic [6:0] ex;
            logic [5:0] ey;
            logic [7:0] ed;
            logic       ef;
            ex = (i == 384) ? 7'd0 : 7'(i % 96);
            ey = (i == 384) ? 6'd60 : 6'(60 + i / 96);
            ed = (i == 384) ? 8'h5A : 8'(i);
            ef = (i == 383);
            if ({qx[i], qy[i], qd[i], qf[i]} !== {ex, ey, ed, ef}) begin
                errors++;
                $display("FAIL frame_px[%0d]: got (%0d,%0d,%h,%b) want (%0d,%0d,%h,%b)",
                         i, qx[i], qy[i], qd[i], qf[i], ex, ey, ed, ef);
            end
            checks++;
        end
    endtask

    task automatic test_window();
        logic [6:0] ex[7] = '{10, 11, 12, 10, 11, 12, 10};
        logic [5:0] ey[7] = '{5, 5, 5, 6, 6, 6, 5};
        spi_byte(8'h15, 1'b0); spi_byte(8'd10, 1'b0); spi_byte(8'd12, 1'b0);
        spi_byte(8'h75, 1'b0); spi_byte(8'd5, 1'b0); spi_byte(8'd6, 1'b0);
        flush();
        clear_q();
        for (int i = 0; i < 7; i++) spi_byte(8'(8'hC0 + i), 1'b1);
        flush();
        if (qx.size() !== 7) begin
            errors++; $display("FAIL window_count: got %0d want 7", qx.size());
        end
        checks++;
        for (int i = 0; i < 7 && i < qx.size(); i++) begin
            if ({qx[i], qy[i], qd[i], qf[i]} !== {ex[i], ey[i], 8'(8'hC0 + i), (i == 5)}) begin
                errors++;
                $display("FAIL window_px[%0d]: got (%0d,%0d,%h,%b) want (%0d,%0d,%h,%b)",
                         i, qx[i], qy[i], qd[i], qf[i], ex[i], ey[i], 8'(8'hC0 + i), (i == 5));
            end
            checks++;
        end
    endtask

    // Cursor is at (11,5) inside window 10..12 x 5..6 on entry.
    task automatic test_abort();
        logic [6:0] ex[3] = '{11, 12, 10};
        logic [5:0] ey[3] = '{5, 5, 6};
        logic [7:0] ed[3] = '{8'hAA, 8'h01, 8'h02};
        spi_byte(8'h15, 1'b0); spi_byte(8'h20, 1'b0);
        clear_q();
        spi_byte(8'hAA, 1'b1);
        spi_byte(8'h01, 1'b1);
        spi_byte(8'h02, 1'b1);
        flush();
        if (err_cnt !== 8'd1) begin
            errors++; $display("FAIL abort_err_cnt: got %0d want 1", err_cnt);
        end
        checks++;
        if (qx.size() !== 3) begin
            errors++; $display("FAIL abort_count: got %0d want 3", qx.size());
        end
        checks++;
        for (int i = 0; i < 3 && i < qx.size(); i++) begin
            if ({qx[i], qy[i], qd[i]} !== {ex[i], ey[i], ed[i]}) begin
                errors++;
                $display("FAIL abort_px[%0d]: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                         i, qx[i], qy[i], qd[i], ex[i], ey[i], ed[i]);
            end
            checks++;
        end
    endtask

    task automatic test_partial();
        do_reset();
        spi_byte(8'hAF, 1'b0);
        flush();
        clear_q();
        oled_csn = 1'b0;
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b1);
        oled_clk = 1'b0;
        wait_cyc(2);
        oled_csn = 1'b1;
        wait_cyc(4);
        spi_byte(8'hAE, 1'b0);
        flush();
        if (err_cnt !== 8'd1) begin
            errors++; $display("FAIL partial_err_cnt: got %0d want 1", err_cnt);
        end
        checks++;
        if ({display_on, cmd_byte} !== {1'b0, 8'hAE}) begin
            errors++;
            $display("FAIL partial_disp: got on=%b byte=%h want 0 ae", display_on, cmd_byte);
        end
        checks++;
        if (qx.size() !== 0) begin
            errors++; $display("FAIL partial_no_pix: got %0d writes want 0", qx.size());
        end
        checks++;
    endtask

    task automatic test_long_cmd();
        int c0;
        c0 = cmd_cnt;
        clear_q();
        spi_byte(8'h22, 1'b0);
        for (int i = 0; i < 10; i++) spi_byte(8'(8'h75 + i), 1'b0);
        flush();
        if (qx.size() !== 0 || cmd_cnt - c0 !== 1) begin
            errors++;
            $display("FAIL long_cmd_consume: got writes=%0d cmds=%0d want 0 1", qx.size(), cmd_cnt - c0);
        end
        checks++;
        spi_byte(8'h3C, 1'b1);
        flush();
        if (qx.size() !== 1 || {qx[0], qy[0], qd[0]} !== {7'd0, 6'd0, 8'h3C}) begin
            errors++;
            $display("FAIL long_cmd_pixel: got n=%0d (%0d,%0d,%h) want 1 (0,0,3c)",
                     qx.size(), qx[0], qy[0], qd[0]);
        end
        checks++;
        if (err_cnt !== 8'd1) begin
            errors++; $display("FAIL long_cmd_err: got %0d want 1", err_cnt);
        end
        checks++;
    endtask

    task automatic test_resn();
        logic [6:0] ex[3] = '{3, 0, 1};
        logic [7:0] ed[3] = '{8'h01, 8'h11, 8'h22};
        spi_byte(8'h15, 1'b0); spi_byte(8'd3, 1'b0); spi_byte(8'd3, 1'b0);
        flush();
        clear_q();
        spi_byte(8'h01, 1'b1);
        for (int i = 0; i < 4; i++) spi_bit(1'b0, 1'b1);
        oled_clk = 1'b0;
        oled_resn = 1'b0;
        wait_cyc(4);
        oled_resn = 1'b1;
        wait_cyc(4);
        spi_byte(8'h11, 1'b1);
        spi_byte(8'h22, 1'b1);
        flush();
        if (qx.size() !== 3) begin
            errors++; $display("FAIL resn_count: got %0d want 3", qx.size());
        end
        checks++;
        for (int i = 0; i < 3 && i < qx.size(); i++) begin
            if ({qx[i], qy[i], qd[i]} !== {ex[i], 6'd0, ed[i]}) begin
                errors++;
                $display("FAIL resn_px[%0d]: got (%0d,%0d,%h) want (%0d,0,%h)",
                         i, qx[i], qy[i], qd[i], ex[i], ed[i]);
            end
            checks++;
        end
        if (err_cnt !== 8'd1) begin
            errors++; $display("FAIL resn_err_kept: got %0d want 1", err_cnt);
        end
        checks++;
    endtask

    task automatic test_clamp_inverted();
        spi_byte(8'h15, 1'b0); spi_byte(8'hF5, 1'b0); spi_byte(8'h60, 1'b0);
        spi_byte(8'h75, 1'b0); spi_byte(8'h7F, 1'b0); spi_byte(8'h7F, 1'b0);
        flush();
        clear_q();
        spi_byte(8'h99, 1'b1);
        flush();
        if (qx.size() !== 1 || {qx[0], qy[0], qf[0]} !== {7'd95, 6'd63, 1'b1}) begin
            errors++;
            $display("FAIL clamp_px: got n=%0d (%0d,%0d,fd=%b) want 1 (95,63,fd=1)",
                     qx.size(), qx[0], qy[0], qf[0]);
        end
        checks++;
        spi_byte(8'h15, 1'b0); spi_byte(8'd20, 1'b0); spi_byte(8'd10, 1'b0);
        spi_byte(8'h75, 1'b0); spi_byte(8'd0, 1'b0); spi_byte(8'd63, 1'b0);
        flush();
        clear_q();
        for (int i = 0; i < 3; i++) spi_byte(8'(i), 1'b1);
        flush();
        if (qx.size() !== 3) begin
            errors++; $display("FAIL inverted_count: got %0d want 3", qx.size());
        end
        checks++;
        for (int i = 0; i < 3 && i < qx.size(); i++) begin
            if ({qx[i], qy[i]} !== {7'd20, 6'(i)}) begin
                errors++;
                $display("FAIL inverted_px[%0d]: got (%0d,%0d) want (20,%0d)", i, qx[i], qy[i], i);
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_cmd_latency();
        test_frame();
        test_window();
        test_abort();
        test_partial();
        test_long_cmd();
        test_resn();
        test_clamp_inverted();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
